// File: rtl/rr_arbiter_2x1_pkg.sv
// Shared interconnect definitions for the 2:1 round-robin arbiter: FSM state
// encoding and one-hot grant constants.
package rr_arbiter_2x1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rr_arbiter_2x1.sv
// Two-master round-robin arbiter driving a downstream 2:1 payload mux.
// Grant, mux select and mux enable come straight from flops.
module rr_arbiter_2x1
    import rr_arbiter_2x1_pkg::*;
#(
    parameter bit LAST_LOCK = 1'b0
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       M0_VALID,
    input  logic       M1_VALID,
    input  logic       M0_LAST,
    input  logic       M1_LAST,
    input  logic       S_READY,
    output logic       S_VALID,
    output logic       M0_READY,
    output logic       M1_READY,
    output logic       MUX_SEL,
    output logic       MUX_EN,
    output logic [1:0] GRANT
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_g_q;
    logic       last_g_d;
    logic [1:0] grant_q;
    logic       mux_en_q;
    logic       mux_sel_q;
    logic       release_s;

    // On a tie the master that was not served last wins.
    function automatic arb_state_e rr_pick(input logic v0, input logic v1, input logic last_g);
        arb_state_e pick;
        case ({v1, v0})
            2'b01:   pick = ST_GNT0;
            2'b10:   pick = ST_GNT1;
            2'b11:   pick = last_g ? ST_GNT0 : ST_GNT1;
            default: pick = ST_IDLE;
        endcase
        return pick;
    endfunction

    // Slave-side routes gated by the registered grant.
    always_comb begin
        S_VALID  = (grant_q[0] & M0_VALID) | (grant_q[1] & M1_VALID);
        M0_READY = grant_q[0] & S_READY;
        M1_READY = grant_q[1] & S_READY;
    end

    // Release on handshake (optionally only on the LAST beat), then re-arbitrate
    // in the same cycle so back-to-back grants have no bubble.
    always_comb begin
        state_d   = state_q;
        last_g_d  = last_g_q;
        release_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = rr_pick(M0_VALID, M1_VALID, last_g_q);
            end
            ST_GNT0: begin
                release_s = S_VALID & S_READY & (LAST_LOCK ? M0_LAST : 1'b1);
                if (release_s) begin
                    last_g_d = 1'b0;
                    state_d  = rr_pick(M0_VALID, M1_VALID, 1'b0);
                end else begin
                    state_d  = ST_GNT0;
                end
            end
            ST_GNT1: begin
                release_s = S_VALID & S_READY & (LAST_LOCK ? M1_LAST : 1'b1);
                if (release_s) begin
                    last_g_d = 1'b1;
                    state_d  = rr_pick(M0_VALID, M1_VALID, 1'b1);
                end else begin
                    state_d  = ST_GNT1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, round-robin pointer and registered mux controls.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            last_g_q  <= 1'b1;
            grant_q   <= GRANT_NONE;
            mux_en_q  <= 1'b0;
            mux_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_g_q  <= last_g_d;
            grant_q   <= state_d;
            mux_en_q  <= (state_d != ST_IDLE);
            mux_sel_q <= (state_d == ST_GNT1);
        end
    end

    assign GRANT   = grant_q;
    assign MUX_EN  = mux_en_q;
    assign MUX_SEL = mux_sel_q;

endmodule

// File: tb/tb_rr_arbiter_2x1.sv
// Directed self-checking bench for rr_arbiter_2x1; dut0 releases on any
// handshake, dut1 only on a LAST handshake.
module tb_rr_arbiter_2x1;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       M0_VALID = 1'b0, M1_VALID = 1'b0;
    logic       M0_LAST = 1'b0, M1_LAST = 1'b0;
    logic       S_READY = 1'b0;
    logic       s_valid0, m0_ready0, m1_ready0, mux_sel0, mux_en0;
    logic [1:0] grant0;
    logic       s_valid1, m0_ready1, m1_ready1, mux_sel1, mux_en1;
    logic [1:0] grant1;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 ACLK = ~ACLK;

    rr_arbiter_2x1 #(.LAST_LOCK(1'b0)) dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .M0_VALID(M0_VALID), .M1_VALID(M1_VALID),
        .M0_LAST(M0_LAST), .M1_LAST(M1_LAST), .S_READY(S_READY), .S_VALID(s_valid0),
        .M0_READY(m0_ready0), .M1_READY(m1_ready0), .MUX_SEL(mux_sel0), .MUX_EN(mux_en0),
        .GRANT(grant0)
    );

    rr_arbiter_2x1 #(.LAST_LOCK(1'b1)) dut1 (
        .ACLK(ACLK), .ARESET(ARESET), .M0_VALID(M0_VALID), .M1_VALID(M1_VALID),
        .M0_LAST(M0_LAST), .M1_LAST(M1_LAST), .S_READY(S_READY), .S_VALID(s_valid1),
        .M0_READY(m0_ready1), .M1_READY(m1_ready1), .MUX_SEL(mux_sel1), .MUX_EN(mux_en1),
        .GRANT(grant1)
    );

    task automatic do_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        M0_VALID = 1'b0; M1_VALID = 1'b0; M0_LAST = 1'b0; M1_LAST = 1'b0; S_READY = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        M0_VALID = 1'b1; M1_VALID = 1'b1; S_READY = 1'b1;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if (grant0 !== 2'b00 || mux_en0 !== 1'b0 || mux_sel0 !== 1'b0 || s_valid0 !== 1'b0 ||
            m0_ready0 !== 1'b0 || m1_ready0 !== 1'b0) begin
            $display("FAIL reset_outputs: got grant=%b en=%b sel=%b sv=%b r0=%b r1=%b, want all 0",
                     grant0, mux_en0, mux_sel0, s_valid0, m0_ready0, m1_ready0);
            n_fail++;
        end
        n_checks++;
        if (grant1 !== 2'b00 || mux_en1 !== 1'b0 || s_valid1 !== 1'b0) begin
            $display("FAIL reset_outputs_lock: got grant=%b en=%b sv=%b, want 00/0/0",
                     grant1, mux_en1, s_valid1);
            n_fail++;
        end
        M0_VALID = 1'b0; M1_VALID = 1'b0; S_READY = 1'b0;
        ARESET = 1'b0;
    endtask

    task automatic test_idle_single();
        @(negedge ACLK);
        n_checks++;
        if (grant0 !== 2'b00 || mux_en0 !== 1'b0 || s_valid0 !== 1'b0) begin
            $display("FAIL idle: got grant=%b en=%b sv=%b, want 00/0/0", grant0, mux_en0, s_valid0);
            n_fail++;
        end
        M0_VALID = 1'b1;
        #1;
        n_checks++;
        if (grant0 !== 2'b00) begin
            $display("FAIL single_m0_before_edge: got grant=%b, want 00", grant0);
            n_fail++;
        end
        @(negedge ACLK);
        n_checks++;
        if (grant0 !== 2'b01 || mux_en0 !== 1'b1 || mux_sel0 !== 1'b0 || s_valid0 !== 1'b1 ||
            m0_ready0 !== 1'b0) begin
            $display("FAIL single_m0_grant: got grant=%b en=%b sel=%b sv=%b r0=%b, want 01/1/0/1/0",
                     grant0, mux_en0, mux_sel0, s_valid0, m0_ready0);
            n_fail++;
        end
    endtask

    task automatic test_valid_drop();
        M0_VALID = 1'b0; M1_VALID = 1'b1; S_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            n_checks++;
            if (grant0 !== 2'b01 || s_valid0 !== 1'b0 || m1_ready0 !== 1'b0) begin
                $display("FAIL valid_drop_c%0d: got grant=%b sv=%b r1=%b, want 01/0/0",
                         c, grant0, s_valid0, m1_ready0);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp0 [4];
        exp0[0] = 2'b01; exp0[1] = 2'b10; exp0[2] = 2'b01; exp0[3] = 2'b10;
        do_reset();
        M0_VALID = 1'b1; M1_VALID = 1'b1; S_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            n_checks++;
            if (grant0 !== exp0[c] || mux_sel0 !== exp0[c][1] || mux_en0 !== 1'b1 ||
                m0_ready0 !== exp0[c][0] || m1_ready0 !== exp0[c][1]) begin
                $display("FAIL back_to_back_c%0d: got grant=%b sel=%b en=%b r0=%b r1=%b, want grant=%b",
                         c, grant0, mux_sel0, mux_en0, m0_ready0, m1_ready0, exp0[c]);
                n_fail++;
            end
            n_checks++;
            if (grant1 !== 2'b01) begin
                $display("FAIL lock_hold_nonlast_c%0d: got grant=%b, want 01", c, grant1);
                n_fail++;
            end
        end
    endtask

    task automatic test_hold_and_async_reset();
        do_reset();
        M1_VALID = 1'b1; S_READY = 1'b0;
        @(negedge ACLK);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (grant0 !== 2'b10 || mux_sel0 !== 1'b1 || mux_en0 !== 1'b1 || m0_ready0 !== 1'b0 ||
                m1_ready0 !== 1'b0 || s_valid0 !== 1'b1) begin
                $display("FAIL hold_m1_c%0d: got grant=%b sel=%b en=%b r0=%b r1=%b sv=%b, want 10/1/1/0/0/1",
                         c, grant0, mux_sel0, mux_en0, m0_ready0, m1_ready0, s_valid0);
                n_fail++;
            end
            @(negedge ACLK);
        end
        #2;
        ARESET = 1'b1;
        #1;
        n_checks++;
        if (grant0 !== 2'b00 || mux_en0 !== 1'b0 || mux_sel0 !== 1'b0 || s_valid0 !== 1'b0) begin
            $display("FAIL async_reset: got grant=%b en=%b sel=%b sv=%b, want 00/0/0/0",
                     grant0, mux_en0, mux_sel0, s_valid0);
            n_fail++;
        end
        M0_VALID = 1'b1; M1_VALID = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (grant0 !== 2'b01) begin
            $display("FAIL post_reset_tie: got grant=%b, want 01", grant0);
            n_fail++;
        end
    endtask

    task automatic test_last_lock();
        do_reset();
        M0_VALID = 1'b1; M1_VALID = 1'b1; S_READY = 1'b1;
        @(negedge ACLK);
        for (int b = 1; b <= 4; b++) begin
            M0_LAST = (b == 4);
            #1;
            n_checks++;
            if (grant1 !== 2'b01 || m0_ready1 !== 1'b1 || s_valid1 !== 1'b1 || m1_ready1 !== 1'b0) begin
                $display("FAIL burst_beat%0d: got grant=%b r0=%b sv=%b r1=%b, want 01/1/1/0",
                         b, grant1, m0_ready1, s_valid1, m1_ready1);
                n_fail++;
            end
            @(negedge ACLK);
        end
        M0_LAST = 1'b0;
        n_checks++;
        if (grant1 !== 2'b10 || mux_sel1 !== 1'b1) begin
            $display("FAIL burst_handover: got grant=%b sel=%b, want 10/1", grant1, mux_sel1);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_single();
        test_valid_drop();
        test_back_to_back();
        test_hold_and_async_reset();
        test_last_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
